// File: rtl/mc_mem_responder.sv
// mc_mem_responder: unified I/D memory responder with fixed wait states, lane steering and extension.
// Define WJBOT_MEM_FAULT_EN to enable misalignment, range and Funct3 fault detection.
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Adr,
    input  logic [2:0]  Funct3,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Ready,
    output logic        Fault
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d, wd_q, wd_d, rd_q, rd_d;
    logic        we_q, we_d, fault_q, fault_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] a, word, ld, wdat;
    logic        w, legal, is_b, is_h, fault;
    logic [2:0]  f;
    logic [AW-1:0] idx;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  be;
    // IDLE decodes the live inputs so a zero-wait access can respond on the next cycle
    always_comb begin
        a = state_q == IDLE ? Adr : adr_q;
        w = state_q == IDLE ? We : we_q;
        f = state_q == IDLE ? Funct3 : f3_q;
        legal = w ? f <= 3'd2 : (f != 3'd3 && f <= 3'd5);
        is_b = legal && f[1:0] == 2'd0;
        is_h = legal && f[1:0] == 2'd1;
        idx = AW'(a[31:2] % 30'(DEPTH_WORDS));
        word = mem[idx];
        b = word[{a[1:0], 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        ld = is_b ? {{24{b[7] & ~f[2]}}, b} : is_h ? {{16{h[15] & ~f[2]}}, h} : word;
`ifdef WJBOT_MEM_FAULT_EN
        fault = !legal || (is_h && a[0]) || (!is_b && !is_h && a[1:0] != 2'd0)
                || {2'b00, a[31:2]} >= 32'(DEPTH_WORDS);
`else
        fault = 1'b0;
`endif
        be = is_b ? 4'b0001 << a[1:0] : is_h ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdat = is_b ? {4{wd_q[7:0]}} : is_h ? {2{wd_q[15:0]}} : wd_q;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        adr_d = adr_q;
        we_d = we_q;
        f3_d = f3_q;
        wd_d = wd_q;
        rd_d = '0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: if (Req) begin
                adr_d = Adr;
                we_d = We;
                f3_d = Funct3;
                wd_d = WD;
                state_d = WAIT_CYCLES == 0 ? RESP : BUSY;
                cnt_d = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end
            BUSY: begin
                state_d = cnt_q == 4'd0 ? RESP : BUSY;
                cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RESP && state_q != RESP) begin
            rd_d = (w || fault) ? 32'd0 : ld;
            fault_d = fault;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            adr_q <= '0;
            we_q <= 1'b0;
            f3_q <= '0;
            wd_q <= '0;
            rd_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            we_q <= we_d;
            f3_q <= f3_d;
            wd_q <= wd_d;
            rd_q <= rd_d;
            fault_q <= fault_d;
        end
    end
    // The store commits on the edge that ends RESP; a reset arriving first abandons it
    always_ff @(posedge clk) begin
        if (state_q == RESP && we_q && !fault_q && !reset)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
    end
    assign RD = rd_q;
    assign Fault = fault_q;
    assign Ready = state_q == RESP;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: scoreboard bench for a 2-wait-state responder and a zero-wait responder.
module tb_mc_mem_responder;
    localparam int DEPTH = 1024;
    logic clk = 1'b0;
    logic reset;
    logic req[2], we[2], ready[2], fault[2];
    logic [31:0] adr[2], wd[2], rd[2];
    logic [2:0] f3[2];
    typedef struct {
        logic [31:0] rd;
        logic        f;
        int          cyc;
        string       name;
    } exp_t;
    exp_t q0[$], q1[$];
    int tests = 0, fails = 0, cyc = 0;
    bit in_resp[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .Req(req[0]), .We(we[0]), .Adr(adr[0]), .Funct3(f3[0]),
        .WD(wd[0]), .RD(rd[0]), .Ready(ready[0]), .Fault(fault[0]));
    mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .Req(req[1]), .We(we[1]), .Adr(adr[1]), .Funct3(f3[1]),
        .WD(wd[1]), .RD(rd[1]), .Ready(ready[1]), .Fault(fault[1]));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_resp(int d, exp_t e);
        chk({e.name, " rd"}, rd[d], e.rd);
        chk({e.name, " fault"}, 32'(fault[d]), 32'(e.f));
        chk({e.name, " ready cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    // Monitor: pops one expectation per Ready pulse, and checks outputs stay 0 otherwise
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (ready[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected Ready on dut%0d at cycle %0d", d, cyc);
                    end else if (d == 0) chk_resp(0, q0.pop_front());
                    else chk_resp(1, q1.pop_front());
                end else begin
                    chk($sformatf("dut%0d idle RD", d), rd[d], 32'd0);
                    chk($sformatf("dut%0d idle Fault", d), 32'(fault[d]), 32'd0);
                end
            end
        end
    end

    task automatic acc(int d, string name, logic w, logic [31:0] a, logic [2:0] f,
                       logic [31:0] data, logic [31:0] erd, logic ef, bit keep);
        exp_t e;
        int n;
        req[d] = 1'b1;
        we[d] = w;
        adr[d] = a;
        f3[d] = f;
        wd[d] = data;
        e.rd = erd;
        e.f = ef;
        e.name = name;
        e.cyc = cyc + (in_resp[d] ? 1 : 0) + (d == 0 ? 2 : 0) + 1;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        in_resp[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[d] && n < 40);
        tests++;
        if (!ready[d]) begin
            fails++;
            $display("FAIL %s timeout: Ready=0 expected 1", name);
        end
        if (keep) in_resp[d] = 1'b1;
        else begin
            req[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; f3[d] = '0; wd[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset dut%0d RD", d), rd[d], 32'd0);
            chk($sformatf("reset dut%0d Ready", d), 32'(ready[d]), 32'd0);
            chk($sformatf("reset dut%0d Fault", d), 32'(fault[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        acc(0, "sw10", 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0);
        acc(0, "lw10", 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);
        acc(0, "sw10b", 1, 32'h10, 3'd2, 32'h11223344, 32'h0, 0, 0);
        acc(0, "sb13", 1, 32'h13, 3'd0, 32'h000000A5, 32'h0, 0, 0);
        acc(0, "lw after sb", 0, 32'h10, 3'd2, 32'h0, 32'hA5223344, 0, 0);
        acc(0, "lb13", 0, 32'h13, 3'd0, 32'h0, 32'hFFFFFFA5, 0, 0);
        acc(0, "lbu13", 0, 32'h13, 3'd4, 32'h0, 32'h000000A5, 0, 0);
        acc(0, "lh12 a522", 0, 32'h12, 3'd1, 32'h0, 32'hFFFFA522, 0, 0);
        acc(0, "sw10c", 1, 32'h10, 3'd2, 32'h80017FFF, 32'h0, 0, 0);
        acc(0, "lh12", 0, 32'h12, 3'd1, 32'h0, 32'hFFFF8001, 0, 0);
        acc(0, "lhu10", 0, 32'h10, 3'd5, 32'h0, 32'h00007FFF, 0, 0);
        acc(0, "lb11", 0, 32'h11, 3'd0, 32'h0, 32'h0000007F, 0, 0);
        acc(0, "lbu10", 0, 32'h10, 3'd4, 32'h0, 32'h000000FF, 0, 0);
        acc(0, "lb10", 0, 32'h10, 3'd0, 32'h0, 32'hFFFFFFFF, 0, 0);
        acc(0, "sh12", 1, 32'h12, 3'd1, 32'hAAAABEEF, 32'h0, 0, 0);
        acc(0, "lw after sh", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF7FFF, 0, 0);
        acc(0, "b2b lw1", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF7FFF, 0, 1);
        acc(0, "b2b lw2", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF7FFF, 0, 0);
        acc(0, "raw sw30", 1, 32'h30, 3'd2, 32'h0F1E2D3C, 32'h0, 0, 1);
        acc(0, "raw lw30", 0, 32'h30, 3'd2, 32'h0, 32'h0F1E2D3C, 0, 0);
        acc(0, "sw0", 1, 32'h0, 3'd2, 32'h0BADC0DE, 32'h0, 0, 0);
`ifdef WJBOT_MEM_FAULT_EN
        acc(0, "lw misaligned", 0, 32'h2, 3'd2, 32'h0, 32'h0, 1, 0);
        acc(0, "lh odd", 0, 32'h11, 3'd1, 32'h0, 32'h0, 1, 0);
        acc(0, "load f3=011", 0, 32'h10, 3'd3, 32'h0, 32'h0, 1, 0);
        acc(0, "store f3=100", 1, 32'h10, 3'd4, 32'h12345678, 32'h0, 1, 0);
        acc(0, "sw out of range", 1, 32'(4 * DEPTH), 3'd2, 32'hFFFFFFFF, 32'h0, 1, 0);
        acc(0, "lw0 unchanged", 0, 32'h0, 3'd2, 32'h0, 32'h0BADC0DE, 0, 0);
        acc(0, "lw10 unchanged", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF7FFF, 0, 0);
`else
        acc(0, "lw misaligned", 0, 32'h2, 3'd2, 32'h0, 32'h0BADC0DE, 0, 0);
        acc(0, "lh adr3", 0, 32'h3, 3'd1, 32'h0, 32'h00000BAD, 0, 0);
        acc(0, "lh adr1", 0, 32'h1, 3'd1, 32'h0, 32'hFFFFC0DE, 0, 0);
        acc(0, "load f3=011", 0, 32'h0, 3'd3, 32'h0, 32'h0BADC0DE, 0, 0);
        acc(0, "load f3=111", 0, 32'h0, 3'd7, 32'h0, 32'h0BADC0DE, 0, 0);
        acc(0, "store f3=100", 1, 32'h10, 3'd4, 32'h12345678, 32'h0, 0, 0);
        acc(0, "lw10 as sw", 0, 32'h10, 3'd2, 32'h0, 32'h12345678, 0, 0);
        acc(0, "sw wrap", 1, 32'(4 * DEPTH), 3'd2, 32'h5555AAAA, 32'h0, 0, 0);
        acc(0, "lw0 wrapped", 0, 32'h0, 3'd2, 32'h0, 32'h5555AAAA, 0, 0);
`endif
        acc(0, "sw20", 1, 32'h20, 3'd2, 32'hCAFEF00D, 32'h0, 0, 0);
        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; f3[0] = 3'd2; wd[0] = 32'h12345678;
        @(negedge clk);
        reset = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        acc(0, "lw20 after abort", 0, 32'h20, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0);
        acc(1, "w0 sw40", 1, 32'h40, 3'd2, 32'h13579BDF, 32'h0, 0, 1);
        acc(1, "w0 lw40", 0, 32'h40, 3'd2, 32'h0, 32'h13579BDF, 0, 0);
        acc(1, "w0 lbu42", 0, 32'h42, 3'd4, 32'h0, 32'h00000057, 0, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d/%0d left expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_mem_responder.md
# mc_mem_responder

Unified instruction/data memory responder for the multicycle RISC-V core. It sits on the memory side of the core's single memory port and services one fetch, load or store at a time through a Req/Ready handshake. It inserts a fixed, configurable number of wait states, performs byte/halfword/word lane steering with sign or zero extension, and flags illegal accesses.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; word index = Adr[31:2].
- WAIT_CYCLES, 2: BUSY cycles inserted per access, range 0..15.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Req  input  1  access request; sampled only in IDLE.
- We  input  1  1 = store, 0 = load/fetch.
- Adr  input  32  byte address.
- Funct3  input  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW. Fetch uses 010.
- WD  input  32  store data, right-aligned.
- RD  output  32  load data, extended to 32 bits; registered.
- Ready  output  1  one-cycle completion strobe.
- Fault  output  1  access rejected; valid only with Ready.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: on Req=1, capture Adr, We, Funct3 and WD into request registers. Go to BUSY with counter=WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
- BUSY: decrement the counter. At 0, read the addressed word into RD (extended per Funct3) and evaluate Fault, then go to RESP.
- RESP: Ready=1 for exactly one cycle. A non-faulting store writes the byte lanes at the clock edge that ends RESP. Then go unconditionally to IDLE.
- Lane steering:
  - byte lane = Adr[1:0]; halfword lane = Adr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - SB/SH write only the selected lanes; the other bytes are unchanged.
- Store responses: RD=0.
- Fault conditions (with WJBOT_MEM_FAULT_EN):
  - halfword access with Adr[0]=1, or word access with Adr[1:0]≠0;
  - Adr[31:2] ≥ DEPTH_WORDS;
  - Funct3 011, 110 or 111, or a store with Funct3[2]=1.
- On Fault: no array write, RD=0, Fault=1 alongside Ready.
- Ready, RD and Fault hold 0 outside RESP.

## Timing
- Req sampled in cycle 0 → Ready high in cycle WAIT_CYCLES+1, then IDLE in cycle WAIT_CYCLES+2.
- Requester holds Req, We, Adr, Funct3 and WD stable until Ready. These inputs are captured in cycle 0, so later changes are ignored.
- Req still high in the IDLE cycle after Ready starts a new access (back-to-back). The requester drops Req in that cycle otherwise.
- Read-after-write: a load issued right after a store's Ready observes the stored data.
- Reset value of every output: RD=0, Ready=0, Fault=0. State resets to IDLE, counter to 0, request registers to 0. Array contents are not reset.
- Reset asserted mid-access abandons the access; a pending store is not written.
- Req during BUSY or RESP has no effect.

## Configuration
- WJBOT_MEM_FAULT_EN defined: fault detection as above.
- Macro undefined:
  - Fault is tied to 0.
  - Misaligned accesses use Adr[1:0] for lane selection as-is; halfword uses Adr[1], word ignores Adr[1:0].
  - Word index wraps modulo DEPTH_WORDS.
  - Illegal Funct3 is treated as LW/SW.

## Test plan
- Reset, then SW Adr=0x10 WD=0xDEADBEEF, WAIT_CYCLES=2 → Ready in cycle 3 with Fault=0. Then LW 0x10 → RD=0xDEADBEEF.
- SB Adr=0x13 WD=0x000000A5 over word 0x11223344 → LW 0x10 returns 0xA5223344. Then LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- LH 0x12 over 0x8001_7FFF → RD=0xFFFF8001; LHU 0x10 → 0x00007FFF.
- With WJBOT_MEM_FAULT_EN:
  - LW Adr=0x2 → Fault=1, RD=0.
  - SW Adr=4·DEPTH_WORDS → Fault=1, and the memory is unchanged (verify by reading word 0).
- Back-to-back: Req held high for two LWs → Ready pulses in cycles 3 and 7. With WAIT_CYCLES=0, pulses in cycles 1 and 3.
- Reset pulsed in the BUSY cycle of SW 0x20 WD=0x12345678 → no Ready. A subsequent LW 0x20 returns the old contents.
